line_fill_responder: RTL and testbench

LINE_FILL_RESPONDER -- requirements
Module: line_fill_responder

---
 rtl/line_fill_responder.sv | 211 +++++++++++++++++++++
 tb/tb_line_fill_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_responder.sv
// -----------------------------------------------------------------------------
// line_fill_responder
//
// Services cache line fills from a local word-addressed backing store. A fill
// request is accepted in IDLE, waits LATENCY cycles, then streams one whole
// line as LINEITEMS beats on a valid/ready channel. A preload port writes
// single words into the store while the responder is idle.
//
// Optional feature (macro LINE_FILL_CRITICAL_WORD_FIRST_EN):
//   defined   - the burst starts at the requested word and wraps within the line
//   undefined - the burst always returns words 0..LINEITEMS-1 in order
//
// Parameters:
//   LINEITEMS - 32-bit words per line (power of two)
//   MEMLINES  - lines of backing storage (power of two)
//   LATENCY   - cycles of access delay, 1..15
//
// Ports:
//   clock      - single clock, all state on its rising edge
//   reset_n    - asynchronous active-low reset
//   req_valid  - fill request from the cache
//   req_addr   - byte address of the missing word
//   req_ready  - responder can accept a request (IDLE only)
//   rsp_valid  - rsp_data holds a valid beat
//   rsp_data   - fill data word
//   rsp_last   - final beat of the line
//   rsp_ready  - cache accepts the current beat
//   wr_en      - preload write strobe
//   wr_addr    - preload byte address
//   wr_data    - preload data word
//   wr_ready   - preload write is honoured this cycle (IDLE only)
// -----------------------------------------------------------------------------
module line_fill_responder #(
    parameter int LINEITEMS = 16,
    parameter int MEMLINES  = 256,
    parameter int LATENCY   = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    input  logic        rsp_ready,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_ready
);

    localparam int OFF_W  = $clog2(LINEITEMS);
    localparam int LINE_W = $clog2(MEMLINES);
    localparam int ADDR_W = 2 + OFF_W + LINE_W;
    localparam int DEPTH  = MEMLINES * LINEITEMS;

    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINEITEMS - 1);
    localparam logic [3:0]       LAT_INIT  = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic [OFF_W-1:0]    beat_reg, beat_next;
    logic [LINE_W-1:0]   line_reg, line_next;
    logic [OFF_W-1:0]    base_off;

    logic                beat_done;
    logic                last_done;
    logic                wr_fire;
    logic                rd_en;
    logic [OFF_W-1:0]    rd_beat;
    logic [OFF_W-1:0]    rd_off;
    logic [OFF_W+LINE_W-1:0] rd_index;
    logic [OFF_W+LINE_W-1:0] wr_index;

    logic [31:0]         mem [DEPTH];
    logic [31:0]         rd_data_reg;

`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
    logic [OFF_W-1:0]    off_reg, off_next;
    assign base_off = off_reg;

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[31:ADDR_W], req_addr[1:0],
                                wr_addr[31:ADDR_W], wr_addr[1:0]};
`else
    assign base_off = '0;

    // The word offset of the request only matters for critical-word-first.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[31:ADDR_W], req_addr[2 +: OFF_W],
                                req_addr[1:0], wr_addr[31:ADDR_W], wr_addr[1:0]};
`endif

    // -------------------------------------------------------------------------
    // Handshake qualifiers
    // -------------------------------------------------------------------------
    assign beat_done = (state_reg == ST_BURST) && rsp_ready;
    assign last_done = beat_done && (beat_reg == LAST_BEAT);
    assign wr_fire   = wr_en && (state_reg == ST_IDLE);

    // -------------------------------------------------------------------------
    // State register (also holds the fill context)
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            beat_reg  <= '0;
            line_reg  <= '0;
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
            off_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            beat_reg  <= beat_next;
            line_reg  <= line_next;
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
            off_reg   <= off_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        beat_next  = beat_reg;
        line_next  = line_reg;
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
        off_next   = off_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = ST_WAIT;
                    cnt_next   = LAT_INIT;
                    beat_next  = '0;
                    line_next  = req_addr[2+OFF_W +: LINE_W];
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
                    off_next   = req_addr[2 +: OFF_W];
`endif
                end
            end
            ST_WAIT: begin
                // The counter sits at zero for one WAIT cycle; that cycle
                // launches the first read so data is ready with rsp_valid.
                if (cnt_reg == 4'd0) begin
                    state_next = ST_BURST;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_BURST: begin
                if (beat_done) begin
                    // Wraps to zero after the last beat.
                    beat_next = beat_reg + 1'b1;
                end
                if (last_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready = (state_reg == ST_IDLE);
        wr_ready  = (state_reg == ST_IDLE);
        rsp_valid = (state_reg == ST_BURST);
        rsp_last  = (state_reg == ST_BURST) && (beat_reg == LAST_BEAT);
        // Gating on state makes the beat vanish the instant reset asserts.
        rsp_data  = (state_reg == ST_BURST) ? rd_data_reg : '0;
    end

    // -------------------------------------------------------------------------
    // Backing store: one write port (IDLE only), one registered read port.
    // The read register only reloads on entry to BURST or when a non-final
    // beat is taken, so a stalled beat holds its data.
    // -------------------------------------------------------------------------
    assign rd_en    = ((state_reg == ST_WAIT) && (cnt_reg == 4'd0)) ||
                      (beat_done && !last_done);
    assign rd_beat  = (state_reg == ST_BURST) ? (beat_reg + 1'b1) : '0;
    assign rd_off   = base_off + rd_beat;
    assign rd_index = {line_reg, rd_off};
    assign wr_index = wr_addr[2 +: OFF_W+LINE_W];

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem[wr_index] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_index];
        end
    end

endmodule

// File: tb/tb_line_fill_responder.sv
// -----------------------------------------------------------------------------
// tb_line_fill_responder
//
// Directed bench for line_fill_responder with default parameters. A word model
// of the backing store produces expected beats, which are queued when a fill
// is requested and popped as the DUT hands beats over. Follows the DUT build
// for LINE_FILL_CRITICAL_WORD_FIRST_EN when computing beat order.
// -----------------------------------------------------------------------------
module tb_line_fill_responder;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;

    int          tests  = 0;
    int          failed = 0;

    logic [31:0] model [4096];
    logic [31:0] exp_q [$];

    line_fill_responder dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rsp_ready (rsp_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] a, input int b);
        logic [3:0]  off;
        logic [11:0] idx;
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
        off = a[5:2] + 4'(b);
`else
        off = 4'(b);
`endif
        idx = {a[13:6], off};
        return model[idx];
    endfunction

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        logic [11:0] idx;
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        check("wr_ready", {31'b0, wr_ready}, 32'd1);
        idx = {a[13:6], a[5:2]};
        model[idx] = d;
        @(posedge clock); #1;
        wr_en = 1'b0;
        $display("[TB] preload addr=%h data=%h", a, d);
    endtask

    // One complete fill. Called #1 after a clock edge with the DUT idle.
    //   stall_a/stall_b : beat indices where rsp_ready is held low for stall_len
    //   blocked         : drive req_valid and a preload write during the burst
    //   do_wr           : issue a preload write on the same edge as the request
    //   abort_at        : return once this many beats are taken (-1 = never)
    task automatic fill(input logic [31:0] addr, input int stall_a, input int stall_b,
                        input int stall_len, input bit blocked, input bit do_wr,
                        input logic [31:0] wa, input logic [31:0] wd,
                        input int exp_cycles, input int abort_at);
        int n;
        int lat;
        int beats;
        int cyc;
        int stall_left;
        int stalled_at;
        logic [11:0] idx;

        if (do_wr) begin
            idx = {wa[13:6], wa[5:2]};
            model[idx] = wd;
            wr_en   = 1'b1;
            wr_addr = wa;
            wr_data = wd;
        end
        for (int b = 0; b < 16; b++) begin
            exp_q.push_back(exp_word(addr, b));
        end

        req_valid = 1'b1;
        req_addr  = addr;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 200) check("accept_timeout", 32'(n), 32'd0);
        @(posedge clock); #1;
        req_valid = 1'b0;
        wr_en     = 1'b0;

        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd5);

        beats      = 0;
        cyc        = 0;
        stall_left = 0;
        stalled_at = -1;
        while (beats < 16 && cyc < 200) begin
            if (beats == abort_at) break;
            cyc++;
            if ((beats == stall_a || beats == stall_b) && stalled_at != beats) begin
                stall_left = stall_len;
                stalled_at = beats;
            end
            if (stall_left > 0) begin
                rsp_ready = 1'b0;
                stall_left--;
            end else begin
                rsp_ready = 1'b1;
            end
            check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("beat_data", rsp_data, exp_q[0]);
            check("rsp_last", {31'b0, rsp_last}, (beats == 15) ? 32'd1 : 32'd0);
            if (blocked) begin
                check("req_ready_busy", {31'b0, req_ready}, 32'd0);
                check("wr_ready_busy", {31'b0, wr_ready}, 32'd0);
                req_valid = 1'b1;
                req_addr  = addr;
                // Withdraw the write before the edge that returns to IDLE.
                wr_en     = !(rsp_ready && beats == 15);
                wr_addr   = 32'h0000_00C0;
                wr_data   = 32'hDEAD_BEEF;
            end
            if (rsp_ready) begin
                $display("[TB] beat %0d addr=%h data=%h last=%0b", beats, addr, rsp_data, rsp_last);
                void'(exp_q.pop_front());
                beats++;
            end
            @(posedge clock); #1;
        end
        rsp_ready = 1'b1;
        wr_en     = 1'b0;

        if (abort_at < 0) begin
            check("beat_count", 32'(beats), 32'd16);
            check("rsp_cycles", 32'(cyc), 32'(exp_cycles));
            check("rsp_done", {31'b0, rsp_valid}, 32'd0);
            check("idle_after", {31'b0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stray;

        reset_n   = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_last", {31'b0, rsp_last}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_wr_ready", {31'b0, wr_ready}, 32'd1);

        for (int k = 0; k < 16; k++) write_word(32'h0000_00C0 + 32'(4 * k), 32'h0300_0000 + 32'(k));
        for (int k = 0; k < 16; k++) write_word(32'h0000_0100 + 32'(4 * k), 32'h0400_0000 + 32'(k));

        $display("[TB] basic fill 0x000000C0");
        fill(32'h0000_00C0, -1, -1, 0, 1'b0, 1'b0, '0, '0, 16, -1);

        $display("[TB] backpressure fill 0x000000C0");
        fill(32'h0000_00C0, 2, 9, 3, 1'b0, 1'b0, '0, '0, 22, -1);

        $display("[TB] critical word fill 0x000000E8");
        fill(32'h0000_00E8, -1, -1, 0, 1'b0, 1'b0, '0, '0, 16, -1);

        $display("[TB] reset mid-burst fill 0x000000C0");
        fill(32'h0000_00C0, -1, -1, 0, 1'b0, 1'b0, '0, '0, 16, 7);
        reset_n = 1'b0;
        #1;
        check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("abort_rsp_last", {31'b0, rsp_last}, 32'd0);
        check("abort_rsp_data", rsp_data, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        check("abort_req_ready", {31'b0, req_ready}, 32'd1);
        stray = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (rsp_valid !== 1'b0) stray++;
        end
        check("no_stray_beats", 32'(stray), 32'd0);

        $display("[TB] refetch after reset 0x000000C0");
        fill(32'h0000_00C0, -1, -1, 0, 1'b0, 1'b0, '0, '0, 16, -1);

        $display("[TB] blocked request and write during burst");
        fill(32'h0000_00C0, -1, -1, 0, 1'b1, 1'b0, '0, '0, 16, -1);
        fill(32'h0000_00C0, -1, -1, 0, 1'b0, 1'b0, '0, '0, 16, -1);

        $display("[TB] aliased fill 0x000040C0");
        fill(32'h0000_40C0, -1, -1, 0, 1'b0, 1'b0, '0, '0, 16, -1);

        $display("[TB] same-edge write and fill 0x00000100");
        fill(32'h0000_0100, -1, -1, 0, 1'b0, 1'b1, 32'h0000_0100, 32'hA5A5_0000, 16, -1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
